// File: rtl/sap1_sequencer.sv
// SAP-1 control sequencer: microstep counter with a combinational microcode decode.
// Build macro SEQ_EARLY_RETIRE_EN retires each instruction after its last active microstep.
module sap1_sequencer #(
    parameter int STEPS = 5,
    parameter int OPW   = 4
) (
    input  logic           mclk,
    input  logic           i_rst_n,
    input  logic           mclk_en,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_flag_carry,
    input  logic           i_flag_zero,
    output logic           o_pc_count_en,
    output logic           o_pc_load_en,
    output logic           o_pc_halt,
    output logic [11:0]    o_ctrl,
    output logic [2:0]     o_step,
    output logic           o_halted
);

    localparam int PC_OUT   = 0;
    localparam int MAR_LOAD = 1;
    localparam int RAM_OUT  = 2;
    localparam int RAM_LOAD = 3;
    localparam int IR_LOAD  = 4;
    localparam int IR_OUT   = 5;
    localparam int A_LOAD   = 6;
    localparam int A_OUT    = 7;
    localparam int B_LOAD   = 8;
    localparam int ALU_OUT  = 9;
    localparam int ALU_SUB  = 10;
    localparam int OUT_LOAD = 11;

    localparam logic [OPW-1:0] OP_LDA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(6);
    localparam logic [OPW-1:0] OP_JC  = OPW'(7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
    localparam logic [OPW-1:0] OP_OUT = OPW'(14);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    logic [2:0]  step_reg;
    logic [2:0]  step_next;
    logic        halted_reg;
    logic        halted_next;
    logic [2:0]  last_step;
    logic [11:0] ctrl_dec;
    logic        count_dec;
    logic        load_dec;
    logic        halt_dec;

    // Final microstep of the current instruction before the counter wraps.
    always_comb begin
        last_step = LAST_STEP;
`ifdef SEQ_EARLY_RETIRE_EN
        case (i_opcode)
            OP_LDA, OP_STA:                       last_step = 3'd3;
            OP_ADD, OP_SUB:                       last_step = 3'd4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: last_step = 3'd2;
            OP_HLT:                               last_step = LAST_STEP;
            default:                              last_step = 3'd1;
        endcase
`endif
    end

    // HLT parks the counter at T3 and latches halted until reset.
    always_comb begin
        step_next   = step_reg;
        halted_next = halted_reg;
        if (!halted_reg) begin
            if (i_opcode == OP_HLT && step_reg == 3'd2) begin
                halted_next = 1'b1;
                step_next   = 3'd3;
            end else if (step_reg >= last_step) begin
                step_next = 3'd0;
            end else begin
                step_next = step_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_reg   <= 3'd0;
            halted_reg <= 1'b0;
        end else if (mclk_en) begin
            step_reg   <= step_next;
            halted_reg <= halted_next;
        end
    end

    always_comb begin
        ctrl_dec  = '0;
        count_dec = 1'b0;
        load_dec  = 1'b0;
        halt_dec  = 1'b0;
        if (halted_reg) begin
            halt_dec = 1'b1;
        end else begin
            case (step_reg)
                3'd0: begin
                    ctrl_dec[PC_OUT]   = 1'b1;
                    ctrl_dec[MAR_LOAD] = 1'b1;
                end
                3'd1: begin
                    ctrl_dec[RAM_OUT] = 1'b1;
                    ctrl_dec[IR_LOAD] = 1'b1;
                    count_dec         = 1'b1;
                end
                3'd2: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl_dec[IR_OUT]   = 1'b1;
                            ctrl_dec[MAR_LOAD] = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl_dec[IR_OUT] = 1'b1;
                            ctrl_dec[A_LOAD] = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl_dec[IR_OUT] = 1'b1;
                            load_dec         = 1'b1;
                        end
                        OP_JC: begin
                            ctrl_dec[IR_OUT] = i_flag_carry;
                            load_dec         = i_flag_carry;
                        end
                        OP_JZ: begin
                            ctrl_dec[IR_OUT] = i_flag_zero;
                            load_dec         = i_flag_zero;
                        end
                        OP_OUT: begin
                            ctrl_dec[A_OUT]    = 1'b1;
                            ctrl_dec[OUT_LOAD] = 1'b1;
                        end
                        OP_HLT:  halt_dec = 1'b1;
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (i_opcode)
                        OP_LDA: begin
                            ctrl_dec[RAM_OUT] = 1'b1;
                            ctrl_dec[A_LOAD]  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_dec[RAM_OUT] = 1'b1;
                            ctrl_dec[B_LOAD]  = 1'b1;
                        end
                        OP_STA: begin
                            ctrl_dec[A_OUT]    = 1'b1;
                            ctrl_dec[RAM_LOAD] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                        ctrl_dec[ALU_OUT] = 1'b1;
                        ctrl_dec[A_LOAD]  = 1'b1;
                        ctrl_dec[ALU_SUB] = (i_opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ctrl        = ctrl_dec;
    assign o_pc_count_en = count_dec;
    assign o_pc_load_en  = load_dec;
    assign o_pc_halt     = halt_dec;
    assign o_step        = step_reg;
    assign o_halted      = halted_reg;

endmodule

// File: doc/sap1_sequencer.md
SAP1_SEQUENCER -- requirements
Module: sap1_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 5, meaning number of microsteps per instruction (T0..T4); the step counter is 3 bits.
REQ-002 SHALL have parameter OPW, default 4, meaning opcode width.
REQ-003 SHALL have port mclk, input, 1, meaning the single system clock; all state updates on posedge mclk.
REQ-004 SHALL have port i_rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port mclk_en, input, 1, meaning clock-enable; state advances only when high.
REQ-006 SHALL have port i_opcode, input, OPW, meaning upper nibble of the instruction register.
REQ-007 SHALL have port i_flag_carry, input, 1, meaning ALU carry flag, registered upstream.
REQ-008 SHALL have port i_flag_zero, input, 1, meaning ALU zero flag, registered upstream.
REQ-009 SHALL have port o_pc_count_en, output, 1, meaning program counter increment request.
REQ-010 SHALL have port o_pc_load_en, output, 1, meaning program counter jump load.
REQ-011 SHALL have port o_pc_halt, output, 1, meaning program counter freeze.
REQ-012 SHALL have port o_ctrl, output, 12, meaning datapath strobes; bit map 0 pc_out, 1 mar_load, 2 ram_out, 3 ram_load, 4 ir_load, 5 ir_out, 6 a_load, 7 a_out, 8 b_load, 9 alu_out, 10 alu_sub, 11 out_load.
REQ-013 SHALL have port o_step, output, 3, meaning current microstep; and port o_halted, output, 1, meaning halted state.

Function
REQ-014 Step counter SHALL advance T(n)->T(n+1) on each mclk with mclk_en=1, and SHALL wrap T(STEPS-1)->T0; with mclk_en=0 it SHALL hold.
REQ-015 All outputs SHALL be combinational decodes of step, i_opcode, flags and halted; strobes are level signals for the whole step.
REQ-016 T0 SHALL assert pc_out and mar_load, for every opcode.
REQ-017 T1 SHALL assert ram_out, ir_load and o_pc_count_en, for every opcode.
REQ-018 Opcode 0x1 LDA SHALL assert ir_out+mar_load at T2, then ram_out+a_load at T3.
REQ-019 Opcodes 0x2 ADD and 0x3 SUB SHALL assert ir_out+mar_load at T2, ram_out+b_load at T3, and alu_out+a_load at T4; SUB SHALL also assert alu_sub at T4.
REQ-020 Opcode 0x4 STA SHALL assert ir_out+mar_load at T2, then a_out+ram_load at T3.
REQ-021 Opcode 0x5 LDI SHALL assert ir_out+a_load at T2.
REQ-022 Opcode 0x6 JMP SHALL assert ir_out+o_pc_load_en at T2; 0x7 JC and 0x8 JZ SHALL do the same only if i_flag_carry or i_flag_zero respectively is 1 during T2, otherwise nothing.
REQ-023 Opcode 0xE OUT SHALL assert a_out+out_load at T2.
REQ-024 Opcode 0xF HLT SHALL assert o_pc_halt at T2; at the end of T2 (mclk_en=1) halted SHALL set.
REQ-025 0x0 NOP and all undefined opcodes SHALL assert nothing beyond T0/T1.
REQ-026 While halted: o_pc_halt=1, o_halted=1, o_ctrl=0, o_pc_count_en=0, o_pc_load_en=0, and the step SHALL freeze at T3; only reset SHALL clear halted.
REQ-027 o_pc_count_en and o_pc_load_en SHALL never be high in the same step.

Reset
REQ-028 i_rst_n=0 SHALL immediately, asynchronously, force step=T0 and halted=0, aborting any instruction mid-step; outputs then show T0 decode (o_ctrl=0x003, all PC controls 0).
REQ-029 Release SHALL be synchronous-safe; first advance occurs on the first mclk edge with mclk_en=1 after deassertion.

Configuration
REQ-030 Macro SEQ_EARLY_RETIRE_EN: when defined, the step SHALL wrap to T0 after each opcode's last active step (LDA/STA after T3; LDI/JMP/JC/JZ/OUT after T2; NOP/undefined after T1; ADD/SUB after T4), with HLT unchanged; when undefined, every instruction SHALL take STEPS cycles (REQ-014).

Verification
REQ-031 Reset mid-T3 of ADD -> o_step=0 and o_ctrl=0x003 without a clock edge; halted=0.
REQ-032 LDA then ADD, mclk_en=1 continuously, macro off -> 10 cycles total; a_load high at ADD T4 with alu_out; o_pc_count_en high exactly at cycles 1 and 6.
REQ-033 JC with carry=0, then JC with carry=1 -> no o_pc_load_en on the first, o_pc_load_en+ir_out at T2 on the second.
REQ-034 HLT -> o_pc_halt at T2; from next edge o_halted=1, o_step stuck at 3, o_ctrl=0 for 20+ cycles.
REQ-035 mclk_en toggled 1-0-0-1 during SUB -> step advances only on enabled edges; alu_sub is seen only at T4.
REQ-036 With SEQ_EARLY_RETIRE_EN, LDI, OUT and NOP in sequence -> 3+3+2 = 8 cycles, o_step returning to 0 after T2, T2 and T1 respectively.
